// File: rtl/spi_mem_port.sv
// spi_mem_port: serialises one controller memory request at a time as an SPI
// mode-0 READ (0x03) or WRITE (0x02) frame to the flash (PC) or RAM (MAR).
// Frame layout, MSB first: command byte, 24-bit address, data byte.
module spi_mem_port #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            mem_op,
   input  logic                  addr_sel,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  mem_op_done,
   output logic                  busy,
   output logic                  spi_sck,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_cs_flash_n,
   output logic                  spi_cs_ram_n
);

   localparam int unsigned FRAME_BITS = 40;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned SPI_ADDR_W = 24;

   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   localparam logic [BYTE_W-1:0] CMD_READ  = 8'h03;
   localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      DONE     = 2'd2,
      WAIT_NOP = 2'd3
   } state_t;

   state_t                  state;
   logic [FRAME_BITS-1:0]   shift_q;
   logic [CNT_W-1:0]        bit_cnt;
   logic [BYTE_W-1:0]       rx_q;
   logic                    is_read_q;

   logic                    req_read_c;
   logic                    req_write_c;
   logic [FRAME_BITS-1:0]   frame_c;
   logic [BYTE_W-1:0]       rx_next_c;

   // Decode the request and assemble the frame from the live inputs; only
   // consumed in the IDLE cycle that latches it.
   always_comb begin
      req_read_c  = (mem_op == OP_READ);
      req_write_c = (mem_op == OP_WRITE);
      frame_c     = {(req_read_c ? CMD_READ : CMD_WRITE),
                     SPI_ADDR_W'(addr),
                     (req_read_c ? 8'h00 : BYTE_W'(data_in))};
      rx_next_c   = {rx_q[BYTE_W-2:0], spi_miso};
   end

   // Transaction FSM with registered SPI pins, chip selects and status.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= IDLE;
         shift_q        <= '0;
         bit_cnt        <= '0;
         rx_q           <= '0;
         is_read_q      <= 1'b0;
         data_out       <= '0;
         mem_op_done    <= 1'b0;
         busy           <= 1'b0;
         spi_sck        <= 1'b0;
         spi_mosi       <= 1'b0;
         spi_cs_flash_n <= 1'b1;
         spi_cs_ram_n   <= 1'b1;
      end else begin
         mem_op_done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_read_c || req_write_c) begin
                  busy      <= 1'b1;
                  is_read_q <= req_read_c;
                  if (req_write_c && !addr_sel) begin
                     // Flash is read-only: complete without touching the bus.
                     state       <= DONE;
                     mem_op_done <= 1'b1;
                  end else begin
                     state          <= SHIFT;
                     shift_q        <= frame_c;
                     bit_cnt        <= '0;
                     spi_sck        <= 1'b0;
                     spi_mosi       <= frame_c[FRAME_BITS-1];
                     spi_cs_flash_n <= addr_sel;
                     spi_cs_ram_n   <= !addr_sel;
                  end
               end
            end

            SHIFT: begin
               if (!spi_sck) begin
                  spi_sck <= 1'b1;
               end else begin
                  // End of high phase: sample MISO, then advance or finish.
                  rx_q    <= rx_next_c;
                  spi_sck <= 1'b0;
                  if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                     state          <= DONE;
                     mem_op_done    <= 1'b1;
                     spi_mosi       <= 1'b0;
                     spi_cs_flash_n <= 1'b1;
                     spi_cs_ram_n   <= 1'b1;
                     if (is_read_q) begin
                        data_out <= DATA_WIDTH'(rx_next_c);
                     end
                  end else begin
                     bit_cnt  <= CNT_W'(bit_cnt + 1'b1);
                     shift_q  <= {shift_q[FRAME_BITS-2:0], 1'b0};
                     spi_mosi <= shift_q[FRAME_BITS-2];
                  end
               end
            end

            DONE: begin
               state <= WAIT_NOP;
            end

            WAIT_NOP: begin
               // Hold off until the controller withdraws its request.
               if (!(req_read_c || req_write_c)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_port.sv
// Self-checking bench for spi_mem_port: SPI slave model on MISO, frame
// monitor on MOSI, expected frames queued when each request is driven.
module tb_spi_mem_port;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  mem_op = 2'd0;
   logic        addr_sel = 1'b0;
   logic [15:0] addr = 16'h0;
   logic [7:0]  data_in = 8'h0;
   logic [7:0]  data_out;
   logic        mem_op_done;
   logic        busy;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;
   logic        spi_cs_flash_n;
   logic        spi_cs_ram_n;

   int checks   = 0;
   int failures = 0;

   logic [39:0] exp_q[$];
   logic [39:0] obs_q[$];
   logic [7:0]  miso_byte = 8'h00;
   logic [7:0]  exp_data  = 8'h00;

   int          mon_bits = 0;
   logic [39:0] mon_frame = '0;

   spi_mem_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_op         (mem_op),
      .addr_sel       (addr_sel),
      .addr           (addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .mem_op_done    (mem_op_done),
      .busy           (busy),
      .spi_sck        (spi_sck),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .spi_cs_flash_n (spi_cs_flash_n),
      .spi_cs_ram_n   (spi_cs_ram_n)
   );

   always #5 clock = ~clock;

   // SPI slave model: collect MOSI on high phases, present MISO on low phases.
   always @(negedge clock) begin
      if (spi_cs_flash_n && spi_cs_ram_n) begin
         mon_bits = 0;
         spi_miso = 1'b0;
      end else if (spi_sck) begin
         mon_frame = {mon_frame[38:0], spi_mosi};
         mon_bits  = mon_bits + 1;
         if (mon_bits == 40) begin
            obs_q.push_back(mon_frame);
            mon_bits = 0;
         end
      end else begin
         if (mon_bits >= 32) spi_miso = miso_byte[39 - mon_bits];
         else                spi_miso = 1'b0;
      end
   end

   function automatic logic [39:0] mk_frame(input logic rd, input logic [15:0] a,
                                            input logic [7:0] d);
      mk_frame = {(rd ? 8'h03 : 8'h02), 8'h00, a, (rd ? 8'h00 : d)};
   endfunction

   // Drive one request and observe 90 cycles; cycle k = k-th negedge after drive.
   task automatic run_txn(input logic [1:0] op, input logic sel, input logic [15:0] a,
                          input logic [7:0] d, input bit churn, input bit drop,
                          input bit release_req,
                          output int done_cyc, output int done_cnt, output int sel_lo,
                          output int other_lo, output int first_lo, output int last_lo);
      logic sel_cs, oth_cs;
      done_cyc = -1; done_cnt = 0; sel_lo = 0; other_lo = 0; first_lo = -1; last_lo = -1;
      mem_op = op; addr_sel = sel; addr = a; data_in = d;
      for (int k = 1; k <= 90; k++) begin
         @(negedge clock);
         sel_cs = sel ? spi_cs_ram_n : spi_cs_flash_n;
         oth_cs = sel ? spi_cs_flash_n : spi_cs_ram_n;
         if (mem_op_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (!sel_cs) begin
            sel_lo++;
            if (first_lo < 0) first_lo = k;
            last_lo = k;
         end
         if (!oth_cs) other_lo++;
         if (churn) begin
            addr     = 16'($urandom);
            data_in  = 8'($urandom);
            addr_sel = ~addr_sel;
         end
         if (drop && k == 10) mem_op = 2'd0;
      end
      if (release_req) begin
         mem_op = 2'd0;
         @(negedge clock);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({data_out, mem_op_done, busy, spi_sck, spi_mosi, spi_cs_flash_n, spi_cs_ram_n}
          !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL reset_values: got dout=%h done=%b busy=%b sck=%b mosi=%b csf=%b csr=%b, want 00 0 0 0 0 1 1",
                  data_out, mem_op_done, busy, spi_sck, spi_mosi, spi_cs_flash_n, spi_cs_ram_n);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_flash_read;
      int dc, dn, sl, ol, fl, ll;
      logic [39:0] e, o;
      miso_byte = 8'hA5;
      exp_q.push_back(mk_frame(1'b1, 16'h1234, 8'h00));
      run_txn(2'd1, 1'b0, 16'h1234, 8'h77, 1'b0, 1'b0, 1'b1, dc, dn, sl, ol, fl, ll);
      exp_data = 8'hA5;
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL flash_read_frame_count: got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            failures++;
            $display("FAIL flash_read_frame: got %h want %h", o, e);
         end
      end
      checks++;
      if (sl != 80 || fl != 1 || ll != 80 || ol != 0) begin
         failures++;
         $display("FAIL flash_read_cs: got low=%0d first=%0d last=%0d other=%0d want 80 1 80 0",
                  sl, fl, ll, ol);
      end
      checks++;
      if (dc != 81 || dn != 1) begin
         failures++;
         $display("FAIL flash_read_done: got cycle=%0d count=%0d want 81 1", dc, dn);
      end
      checks++;
      if (data_out !== exp_data || busy !== 1'b0) begin
         failures++;
         $display("FAIL flash_read_data: got %h busy=%b want %h busy=0", data_out, busy, exp_data);
      end
   endtask

   task automatic test_ram_write(input bit churn);
      int dc, dn, sl, ol, fl, ll;
      logic [39:0] e, o;
      logic [15:0] a;
      logic [7:0]  d;
      a = churn ? 16'h1357 : 16'h00FF;
      d = churn ? 8'hE1 : 8'h3C;
      miso_byte = 8'hFF;
      exp_q.push_back(mk_frame(1'b0, a, d));
      run_txn(2'd2, 1'b1, a, d, churn, churn, 1'b1, dc, dn, sl, ol, fl, ll);
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL ram_write_frame_count churn=%0d: got %0d want 1", churn, obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            failures++;
            $display("FAIL ram_write_frame churn=%0d: got %h want %h", churn, o, e);
         end
      end
      checks++;
      if (sl != 80 || fl != 1 || ol != 0 || dc != 81 || dn != 1) begin
         failures++;
         $display("FAIL ram_write_timing churn=%0d: got low=%0d first=%0d flash_low=%0d done=%0d/%0d want 80 1 0 81/1",
                  churn, sl, fl, ol, dc, dn);
      end
      checks++;
      if (data_out !== exp_data) begin
         failures++;
         $display("FAIL ram_write_data_kept churn=%0d: got %h want %h", churn, data_out, exp_data);
      end
   endtask

   task automatic test_held_request;
      int dc, dn, sl, ol, fl, ll, cs_lo, extra_done;
      logic [39:0] e, o;
      miso_byte = 8'h5A;
      exp_q.push_back(mk_frame(1'b1, 16'h0042, 8'h00));
      run_txn(2'd1, 1'b0, 16'h0042, 8'h00, 1'b0, 1'b0, 1'b0, dc, dn, sl, ol, fl, ll);
      exp_data = 8'h5A;
      cs_lo = 0; extra_done = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         if (!spi_cs_flash_n || !spi_cs_ram_n) cs_lo++;
         if (mem_op_done) extra_done++;
      end
      checks++;
      if (cs_lo != 0 || extra_done != 0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL held_no_restart: got cs_low=%0d done=%0d busy=%b want 0 0 1",
                  cs_lo, extra_done, busy);
      end
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL held_frame_count: got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            failures++;
            $display("FAIL held_frame: got %h want %h", o, e);
         end
      end
      mem_op = 2'd0;
      @(negedge clock);
      miso_byte = 8'h81;
      exp_q.push_back(mk_frame(1'b1, 16'h0043, 8'h00));
      run_txn(2'd1, 1'b0, 16'h0043, 8'h00, 1'b0, 1'b0, 1'b1, dc, dn, sl, ol, fl, ll);
      exp_data = 8'h81;
      checks++;
      if (fl != 1 || dc != 81 || data_out !== exp_data) begin
         failures++;
         $display("FAIL held_second_read: got first=%0d done=%0d data=%h want 1 81 %h",
                  fl, dc, data_out, exp_data);
      end
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL held_second_frame_count: got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            failures++;
            $display("FAIL held_second_frame: got %h want %h", o, e);
         end
      end
   endtask

   task automatic test_illegal_write;
      int dc, dn, sl, ol, fl, ll;
      run_txn(2'd2, 1'b0, 16'h2000, 8'h99, 1'b0, 1'b0, 1'b1, dc, dn, sl, ol, fl, ll);
      checks++;
      if (dc != 1 || dn != 1) begin
         failures++;
         $display("FAIL illegal_write_done: got cycle=%0d count=%0d want 1 1", dc, dn);
      end
      checks++;
      if (sl != 0 || ol != 0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL illegal_write_bus: got flash_low=%0d ram_low=%0d frames=%0d want 0 0 0",
                  sl, ol, obs_q.size());
      end
      checks++;
      if (data_out !== exp_data) begin
         failures++;
         $display("FAIL illegal_write_data: got %h want %h", data_out, exp_data);
      end
   endtask

   task automatic test_reset_mid_frame;
      int dc, dn, sl, ol, fl, ll, cs_lo, dones;
      logic [39:0] e, o;
      miso_byte = 8'hC3;
      mem_op = 2'd1; addr_sel = 1'b1; addr = 16'h0777;
      repeat (30) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      exp_data = 8'h00;
      checks++;
      if ({data_out, mem_op_done, busy, spi_sck, spi_mosi, spi_cs_flash_n, spi_cs_ram_n}
          !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL midreset_values: got dout=%h done=%b busy=%b sck=%b mosi=%b csf=%b csr=%b, want 00 0 0 0 0 1 1",
                  data_out, mem_op_done, busy, spi_sck, spi_mosi, spi_cs_flash_n, spi_cs_ram_n);
      end
      reset = 1'b1; mem_op = 2'd0;
      cs_lo = 0; dones = 0;
      repeat (60) begin
         @(negedge clock);
         if (!spi_cs_flash_n || !spi_cs_ram_n) cs_lo++;
         if (mem_op_done) dones++;
      end
      checks++;
      if (cs_lo != 0 || dones != 0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL midreset_quiet: got cs_low=%0d done=%0d frames=%0d want 0 0 0",
                  cs_lo, dones, obs_q.size());
      end
      miso_byte = 8'h96;
      exp_q.push_back(mk_frame(1'b1, 16'hBEEF, 8'h00));
      run_txn(2'd1, 1'b1, 16'hBEEF, 8'h00, 1'b0, 1'b0, 1'b1, dc, dn, sl, ol, fl, ll);
      exp_data = 8'h96;
      checks++;
      if (dc != 81 || sl != 80 || data_out !== exp_data) begin
         failures++;
         $display("FAIL midreset_next_read: got done=%0d low=%0d data=%h want 81 80 %h",
                  dc, sl, data_out, exp_data);
      end
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL midreset_frame_count: got %0d want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         if (o !== e) begin
            failures++;
            $display("FAIL midreset_frame: got %h want %h", o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_flash_read();
      test_ram_write(1'b0);
      test_held_request();
      test_illegal_write();
      test_reset_mid_frame();
      test_ram_write(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_mem_port.md
# spi_mem_port

Memory port between the control unit and the off-chip SPI devices (program flash and data RAM). It accepts one level-held request at a time from the controller (`mem_op`, `addr_sel`), serialises it as a standard SPI mode-0 READ (0x03) or WRITE (0x02) frame, and pulses `mem_op_done` when the byte has transferred. Read data is held stable on `data_out` until the next read completes. The controller can therefore write it into the register file one cycle after `mem_op_done`.

## Interface
- `ADDR_WIDTH`, default 16: width of `addr`, max 24; zero-extended to the 24-bit SPI address.
- `DATA_WIDTH`, default 8: width of `data_in`/`data_out`; fixed at 8 for the SPI frame.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `mem_op` in 2: 0 NOP, 1 READ, 2 WRITE, 3 treated as NOP.
- `addr_sel` in 1: 0 = PC, selects the flash device; 1 = MAR, selects the RAM device.
- `addr` in ADDR_WIDTH: byte address from the selected address register.
- `data_in` in 8: write data from the ALU/mux path.
- `data_out` out 8: last read byte.
- `mem_op_done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state other than IDLE.
- `spi_sck` out 1: serial clock, clock/2, idle low.
- `spi_mosi` out 1: serial data out.
- `spi_miso` in 1: serial data in.
- `spi_cs_flash_n` out 1: flash chip select, active-low.
- `spi_cs_ram_n` out 1: RAM chip select, active-low.

## Operation
- States: IDLE, SHIFT, DONE, WAIT_NOP.
- **IDLE:**
  - On `mem_op` READ or WRITE, latch op, `addr_sel`, `addr` and `data_in`, then go to SHIFT.
  - NOP or 3 stays in IDLE.
- **SHIFT:**
  - The frame is 40 bits, MSB first: command byte, 24-bit address, data byte.
  - The command byte is 0x03 for READ and 0x02 for WRITE.
  - The address is `addr` zero-extended to 24 bits.
  - The data byte is the latched `data_in` for WRITE and 0x00 for READ.
  - The chip select picked by the latched `addr_sel` is low for the whole frame; the other stays high.
- **Bit timing:** each bit takes two cycles.
  - Low phase: `spi_sck`=0, `spi_mosi` is driven with the bit.
  - High phase: `spi_sck`=1; `spi_miso` is sampled at the clock edge ending the high phase.
  - For READ, the last 8 sampled bits form the result.
- **DONE:**
  - Both chip selects high, `spi_sck`=0, `mem_op_done`=1 for exactly one cycle.
  - On READ, `data_out` takes the result; on WRITE, `data_out` is unchanged.
  - Next state is WAIT_NOP.
- **WAIT_NOP:** stay until `mem_op` is NOP (or 3), then go to IDLE. This stops a still-asserted request from restarting.
- **WRITE with `addr_sel`=PC (flash):** illegal. Go IDLE→DONE→WAIT_NOP with no SPI activity: chip selects stay high, done pulses, `data_out` is unchanged.
- **Inputs during a transaction:** changes to `addr`, `data_in` and `addr_sel` after latch are ignored.
- **Request dropped mid-frame:** if `mem_op` goes to NOP during SHIFT, the frame still completes and done still pulses.

## Timing
- Latency: let cycle 0 be the cycle in which IDLE sees the request.
  - Cycles 1–80: chip select low, 40 bits shifted.
  - Cycle 81: `mem_op_done`=1 and `data_out` is valid.
- Illegal flash write: `mem_op_done` in cycle 1.
- All outputs are registered; none depends combinationally on any input.
- The earliest next request is seen in the first IDLE cycle after `mem_op` has been NOP for at least one cycle.
- Reset values: `data_out`=0, `mem_op_done`=0, `busy`=0, `spi_sck`=0, `spi_mosi`=0, both chip selects=1, state IDLE.
- Reset mid-frame takes effect at the next edge: the frame is abandoned, the chip select is released and no done pulse is produced.

## Test plan
- Flash read: `addr_sel`=0, `addr`=0x1234, READ held; MISO model returns 0xA5 → MOSI carries 0x03,0x00,0x12,0x34,0x00; `spi_cs_flash_n` low in cycles 1–80; `mem_op_done` pulses in cycle 81; `data_out`=0xA5 and stays there until the next read.
- RAM write: `addr_sel`=1, `addr`=0x00FF, `data_in`=0x3C → MOSI carries 0x02,0x00,0x00,0xFF,0x3C; only `spi_cs_ram_n` toggles; `data_out` is unchanged.
- Held request: READ stays asserted for 5 cycles after done → no second frame; NOP for 1 cycle, then READ → new frame starts.
- Illegal flash write: `addr_sel`=0, WRITE → `mem_op_done` in cycle 1; both chip selects stay high throughout.
- Reset mid-frame: `reset`=0 at cycle 30 → next cycle all outputs at reset values; no done pulse; a following READ completes normally.
- Input churn: `addr` and `data_in` toggle every cycle during SHIFT → the frame matches the values latched in cycle 0.
